edge_event_monitor: RTL

Samples a set of asynchronous single-bit signals, detects enabled rising and falling edges per channel, and timestamps each event with a free-running cycle counter. Events are queued and delivered one per handshake to the downstream event logger/printer stage, which formats the "posedge a", "negedge b" and "c changed" style reports. This block is the producer that feeds that reporting stage.

---
 rtl/edge_event_monitor.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/edge_event_monitor.sv
// Edge event monitor: synchronizes asynchronous inputs, detects enabled edges,
// timestamps them and queues them for a downstream event logger.
module edge_event_monitor #(
   parameter int NCH   = 4,
   parameter int TS_W  = 16,
   parameter int DEPTH = 4,
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NCH-1:0]  sig_in,
   input  logic [NCH-1:0]  pos_en,
   input  logic [NCH-1:0]  neg_en,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [CH_W-1:0] evt_ch,
   output logic [1:0]      evt_kind,
   output logic [TS_W-1:0] evt_time,
   output logic            overflow,
   input  logic            clr_ovf
);

   localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};

   logic [NCH-1:0]  s1_r, s2_r, prv_r;
   logic [TS_W-1:0] ts_r;

   logic [NCH-1:0]  pend_r;
   logic [1:0]      pkind_r [NCH];
   logic [TS_W-1:0] ptime_r [NCH];

   logic [NCH-1:0]  rise_s, fall_s, det_s, drain_s, drop_s;
   logic            any_pend_s, pop_s, push_s;
   logic [CH_W-1:0] push_ch_s;
   logic [1:0]      push_kind_s;
   logic [TS_W-1:0] push_time_s;

   // FIFO is a shift register: entry 0 is always the head, so outputs come straight from flops
   logic [DEPTH-1:0] fvld_r, sh_vld_s, place_s, fvld_nxt_s;
   logic [CH_W-1:0]  fch_r   [DEPTH];
   logic [1:0]       fkind_r [DEPTH];
   logic [TS_W-1:0]  ftime_r [DEPTH];
   logic [CH_W-1:0]  sh_ch_s   [DEPTH];
   logic [1:0]       sh_kind_s [DEPTH];
   logic [TS_W-1:0]  sh_time_s [DEPTH];
   logic [CH_W-1:0]  fch_nxt_s   [DEPTH];
   logic [1:0]       fkind_nxt_s [DEPTH];
   logic [TS_W-1:0]  ftime_nxt_s [DEPTH];

   logic ovf_r;

   // Two-flop synchronizer followed by the history flop used for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r  <= {NCH{1'b0}};
         s2_r  <= {NCH{1'b0}};
         prv_r <= {NCH{1'b0}};
      end else begin
         s1_r  <= sig_in;
         s2_r  <= s1_r;
         prv_r <= s2_r;
      end
   end

   // Free-running timestamp, wraps silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_r <= {TS_W{1'b0}};
      end else begin
         ts_r <= ts_r + TS_ONE;
      end
   end

   // Edge detection gated by the per-channel enables
   always_comb begin
      rise_s = s2_r & ~prv_r & pos_en;
      fall_s = ~s2_r & prv_r & neg_en;
      det_s  = rise_s | fall_s;
   end

   // Fixed-priority arbiter: the downward scan leaves the lowest pending channel selected
   always_comb begin
      any_pend_s  = |pend_r;
      push_ch_s   = {CH_W{1'b0}};
      push_kind_s = 2'b00;
      push_time_s = {TS_W{1'b0}};
      for (int i = NCH - 1; i >= 0; i--) begin
         if (pend_r[i]) begin
            push_ch_s   = CH_W'(i);
            push_kind_s = pkind_r[i];
            push_time_s = ptime_r[i];
         end else begin
            push_ch_s   = push_ch_s;
         end
      end
      pop_s  = fvld_r[0] & evt_ready;
      push_s = any_pend_s & (~fvld_r[DEPTH-1] | pop_s);
      for (int i = 0; i < NCH; i++) begin
         drain_s[i] = push_s & (push_ch_s == CH_W'(i));
      end
      drop_s = det_s & pend_r & ~drain_s;
   end

   // Per-channel pending slots; a slot draining this cycle can accept a new event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r <= {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) begin
            pkind_r[i] <= 2'b00;
            ptime_r[i] <= {TS_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (det_s[i] && (!pend_r[i] || drain_s[i])) begin
               pend_r[i]  <= 1'b1;
               pkind_r[i] <= rise_s[i] ? 2'b01 : 2'b10;
               ptime_r[i] <= ts_r;
            end else if (drain_s[i]) begin
               pend_r[i]  <= 1'b0;
            end
         end
      end
   end

   // Pop shifts every entry one place towards the head
   always_comb begin
      for (int j = 0; j < DEPTH - 1; j++) begin
         if (pop_s) begin
            sh_vld_s[j]  = fvld_r[j+1];
            sh_ch_s[j]   = fch_r[j+1];
            sh_kind_s[j] = fkind_r[j+1];
            sh_time_s[j] = ftime_r[j+1];
         end else begin
            sh_vld_s[j]  = fvld_r[j];
            sh_ch_s[j]   = fch_r[j];
            sh_kind_s[j] = fkind_r[j];
            sh_time_s[j] = ftime_r[j];
         end
      end
      if (pop_s) begin
         sh_vld_s[DEPTH-1]  = 1'b0;
         sh_ch_s[DEPTH-1]   = {CH_W{1'b0}};
         sh_kind_s[DEPTH-1] = 2'b00;
         sh_time_s[DEPTH-1] = {TS_W{1'b0}};
      end else begin
         sh_vld_s[DEPTH-1]  = fvld_r[DEPTH-1];
         sh_ch_s[DEPTH-1]   = fch_r[DEPTH-1];
         sh_kind_s[DEPTH-1] = fkind_r[DEPTH-1];
         sh_time_s[DEPTH-1] = ftime_r[DEPTH-1];
      end
   end

   // Push lands in the first free entry after the shift
   always_comb begin
      place_s = {DEPTH{push_s}} & ~sh_vld_s & {sh_vld_s[DEPTH-2:0], 1'b1};
      for (int j = 0; j < DEPTH; j++) begin
         fvld_nxt_s[j] = sh_vld_s[j] | place_s[j];
         if (place_s[j]) begin
            fch_nxt_s[j]   = push_ch_s;
            fkind_nxt_s[j] = push_kind_s;
            ftime_nxt_s[j] = push_time_s;
         end else begin
            fch_nxt_s[j]   = sh_ch_s[j];
            fkind_nxt_s[j] = sh_kind_s[j];
            ftime_nxt_s[j] = sh_time_s[j];
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fvld_r <= {DEPTH{1'b0}};
         for (int j = 0; j < DEPTH; j++) begin
            fch_r[j]   <= {CH_W{1'b0}};
            fkind_r[j] <= 2'b00;
            ftime_r[j] <= {TS_W{1'b0}};
         end
      end else begin
         fvld_r <= fvld_nxt_s;
         for (int j = 0; j < DEPTH; j++) begin
            fch_r[j]   <= fch_nxt_s[j];
            fkind_r[j] <= fkind_nxt_s[j];
            ftime_r[j] <= ftime_nxt_s[j];
         end
      end
   end

   // Sticky overflow; a drop wins over a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (|drop_s) begin
         ovf_r <= 1'b1;
      end else if (clr_ovf) begin
         ovf_r <= 1'b0;
      end
   end

   assign evt_valid = fvld_r[0];
   assign evt_ch    = fch_r[0];
   assign evt_kind  = fkind_r[0];
   assign evt_time  = ftime_r[0];
   assign overflow  = ovf_r;

endmodule
